// File: rtl/sd_block_responder_pkg.sv
// Shared constants and FSM state type for the sector-request responder.
//   SECTOR_BYTES : bytes per sector
//   LAST_BYTE    : final byte index within a sector
//   state_e      : responder FSM state encoding
package c1541_sd_pkg;

  localparam int unsigned SECTOR_BYTES = 512;
  localparam logic [8:0]  LAST_BYTE    = 9'(SECTOR_BYTES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StRdMem,
    StRdPut,
    StWrFetch,
    StWrMem,
    StFill,
    StDrain,
    StDone
  } state_e;

endpackage

// File: rtl/sd_block_responder_if.sv
// Sector-request bus between the track loader (initiator) and a responder.
//   sd_lba        : sector number, initiator -> responder
//   sd_rd / sd_wr : read / write request levels, initiator -> responder
//   sd_ack        : high for the whole transfer, responder -> initiator
//   sd_buff_addr  : byte index within the sector, responder -> initiator
//   sd_buff_dout  : read data into the initiator buffer
//   sd_buff_din   : write data out of the initiator buffer (1-cycle latency)
//   sd_buff_wr    : one-cycle store strobe for sd_buff_dout
interface sd_block_if;

  logic [31:0] sd_lba;
  logic        sd_rd;
  logic        sd_wr;
  logic        sd_ack;
  logic [8:0]  sd_buff_addr;
  logic [7:0]  sd_buff_dout;
  logic [7:0]  sd_buff_din;
  logic        sd_buff_wr;

  modport master (
    output sd_lba, sd_rd, sd_wr, sd_buff_din,
    input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr
  );

  modport slave (
    input  sd_lba, sd_rd, sd_wr, sd_buff_din,
    output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr
  );

endinterface

// File: rtl/sd_block_responder.sv
// Responder side of the sector-request bus, backed by a byte-wide memory.
// Reads stream one sector from memory into the initiator buffer; writes move
// one sector from the initiator buffer into memory. Out-of-range requests are
// completed without touching memory (reads return zeros) and flag err.
//   clk, reset   : clock, synchronous active-high reset
//   sd           : sector-request bus (slave side)
//   img_mounted  : image present
//   img_blocks   : image size in sectors
//   mem_*        : backing memory request/response (mem_ready ends a request)
//   err          : last accepted request was out of range
// All outputs come straight from registers.
module sd_block_responder
  import c1541_sd_pkg::*;
#(
  parameter int unsigned ADDR_W = 24
) (
  input  logic              clk,
  input  logic              reset,
  sd_block_if.slave         sd,
  input  logic              img_mounted,
  input  logic [ADDR_W-10:0] img_blocks,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [7:0]        mem_dout,
  input  logic [7:0]        mem_din,
  input  logic              mem_ready,
  output logic              err
);

  state_e             state_q, state_d;
  logic [ADDR_W-10:0] lba_q, lba_d;
  logic               ack_q, ack_d;
  logic [8:0]         addr_q, addr_d;
  logic [7:0]         bdout_q, bdout_d;
  logic               bwr_q, bwr_d;
  logic               mrd_q, mrd_d;
  logic               mwr_q, mwr_d;
  logic [7:0]         mdout_q, mdout_d;
  logic               err_q, err_d;
  // Second WR_FETCH cycle: buffer data for addr_q is now valid on sd_buff_din.
  logic               fetch_wait_q, fetch_wait_d;

  logic last_byte;
  logic out_of_range;

  assign last_byte    = (addr_q == LAST_BYTE);
  assign out_of_range = !img_mounted ||
                        (sd.sd_lba[31:ADDR_W-9] != '0) ||
                        (sd.sd_lba[ADDR_W-10:0] >= img_blocks);

  always_comb begin
    state_d      = state_q;
    lba_d        = lba_q;
    ack_d        = ack_q;
    addr_d       = addr_q;
    bdout_d      = bdout_q;
    bwr_d        = bwr_q;
    mrd_d        = mrd_q;
    mwr_d        = mwr_q;
    mdout_d      = mdout_q;
    err_d        = err_q;
    fetch_wait_d = fetch_wait_q;

    case (state_q)
      StIdle: begin
        if (sd.sd_wr || sd.sd_rd) begin
          lba_d        = sd.sd_lba[ADDR_W-10:0];
          ack_d        = 1'b1;
          addr_d       = '0;
          err_d        = out_of_range;
          fetch_wait_d = 1'b0;
          // Write wins when both request lines are high.
          if (sd.sd_wr) begin
            state_d = out_of_range ? StDrain : StWrFetch;
          end else if (out_of_range) begin
            state_d = StFill;
            bdout_d = 8'h00;
          end else begin
            state_d = StRdMem;
            mrd_d   = 1'b1;
          end
        end
      end

      StRdMem: begin
        if (mem_ready && mrd_q) begin
          bdout_d = mem_din;
          mrd_d   = 1'b0;
          bwr_d   = 1'b1;
          state_d = StRdPut;
        end
      end

      StRdPut: begin
        bwr_d = 1'b0;
        if (last_byte) begin
          ack_d   = 1'b0;
          state_d = StDone;
        end else begin
          addr_d  = addr_q + 9'd1;
          mrd_d   = 1'b1;
          state_d = StRdMem;
        end
      end

      StWrFetch: begin
        if (!fetch_wait_q) begin
          fetch_wait_d = 1'b1;
        end else begin
          fetch_wait_d = 1'b0;
          mdout_d      = sd.sd_buff_din;
          mwr_d        = 1'b1;
          state_d      = StWrMem;
        end
      end

      StWrMem: begin
        if (mem_ready && mwr_q) begin
          mwr_d = 1'b0;
          if (last_byte) begin
            ack_d   = 1'b0;
            state_d = StDone;
          end else begin
            addr_d  = addr_q + 9'd1;
            state_d = StWrFetch;
          end
        end
      end

      // Strobe low/high alternately; advance after each strobe.
      StFill: begin
        if (!bwr_q) begin
          bwr_d = 1'b1;
        end else begin
          bwr_d = 1'b0;
          if (last_byte) begin
            ack_d   = 1'b0;
            state_d = StDone;
          end else begin
            addr_d = addr_q + 9'd1;
          end
        end
      end

      StDrain: begin
        if (last_byte) begin
          ack_d   = 1'b0;
          state_d = StDone;
        end else begin
          addr_d = addr_q + 9'd1;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      lba_q        <= '0;
      ack_q        <= 1'b0;
      addr_q       <= '0;
      bdout_q      <= '0;
      bwr_q        <= 1'b0;
      mrd_q        <= 1'b0;
      mwr_q        <= 1'b0;
      mdout_q      <= '0;
      err_q        <= 1'b0;
      fetch_wait_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      lba_q        <= lba_d;
      ack_q        <= ack_d;
      addr_q       <= addr_d;
      bdout_q      <= bdout_d;
      bwr_q        <= bwr_d;
      mrd_q        <= mrd_d;
      mwr_q        <= mwr_d;
      mdout_q      <= mdout_d;
      err_q        <= err_d;
      fetch_wait_q <= fetch_wait_d;
    end
  end

  assign sd.sd_ack       = ack_q;
  assign sd.sd_buff_addr = addr_q;
  assign sd.sd_buff_dout = bdout_q;
  assign sd.sd_buff_wr   = bwr_q;
  assign mem_addr        = {lba_q, addr_q};
  assign mem_rd          = mrd_q;
  assign mem_wr          = mwr_q;
  assign mem_dout        = mdout_q;
  assign err             = err_q;

endmodule

// File: tb/tb_sd_block_responder.sv
// Directed self-checking bench for sd_block_responder: a backing-memory model
// with programmable latency, an initiator buffer model with 1-cycle read
// latency, and a negedge monitor of buffer strobes.
module tb_sd_block_responder;

  localparam int unsigned ADDR_W = 24;
  localparam int          MEM_SZ = 32768;

  logic              clk;
  logic              reset;
  logic              img_mounted;
  logic [ADDR_W-10:0] img_blocks;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_wr;
  logic [7:0]        mem_dout;
  logic [7:0]        mem_din;
  logic              mem_ready;
  logic              err;

  sd_block_if sd ();

  sd_block_responder #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .sd         (sd),
    .img_mounted(img_mounted),
    .img_blocks (img_blocks),
    .mem_addr   (mem_addr),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .mem_dout   (mem_dout),
    .mem_din    (mem_din),
    .mem_ready  (mem_ready),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Backing memory: unwritten bytes hold addr[7:0]^addr[16:9].
  function automatic logic [7:0] init_byte(input int a);
    logic [31:0] v;
    v = a;
    return v[7:0] ^ v[16:9];
  endfunction

  logic [7:0] wmem   [MEM_SZ];
  bit         wvalid [MEM_SZ];
  int         lat = 2;
  int         mem_cnt = 0;
  int         wr_done = 0;

  function automatic logic [7:0] mem_byte(input int a);
    return wvalid[a] ? wmem[a] : init_byte(a);
  endfunction

  initial mem_ready = 1'b0;
  initial mem_din   = 8'h00;

  always @(posedge clk) begin
    if ((mem_rd || mem_wr) && !mem_ready) begin
      if (mem_cnt + 1 >= lat) begin
        mem_ready <= 1'b1;
        mem_din   <= mem_byte(int'(mem_addr[14:0]));
        mem_cnt   <= 0;
      end else begin
        mem_cnt <= mem_cnt + 1;
      end
    end else begin
      mem_ready <= 1'b0;
      mem_cnt   <= 0;
    end
    if (mem_wr && mem_ready) begin
      wmem[mem_addr[14:0]]   <= mem_dout;
      wvalid[mem_addr[14:0]] <= 1'b1;
      wr_done                <= wr_done + 1;
    end
  end

  // Initiator buffer: returns 0xA5^index one cycle after the address.
  always @(posedge clk) sd.sd_buff_din <= 8'hA5 ^ sd.sd_buff_addr[7:0];

  // Per-transfer monitor, cleared whenever the test starts a new transfer.
  int         xfer_seq = 0;
  int         seen_seq = 0;
  bit         exp_fill = 1'b0;
  logic [7:0] exp_lba8 = 8'h00;
  int         strobe_cnt = 0;
  int         addr_bad = 0;
  int         data_bad = 0;
  int         last_strobe_cyc = 0;
  bit         rd_seen = 1'b0;
  bit         wr_seen = 1'b0;

  always @(negedge clk) begin
    if (seen_seq != xfer_seq) begin
      seen_seq   <= xfer_seq;
      strobe_cnt <= 0;
      addr_bad   <= 0;
      data_bad   <= 0;
      rd_seen    <= 1'b0;
      wr_seen    <= 1'b0;
    end else begin
      if (sd.sd_buff_wr) begin
        if (sd.sd_buff_addr != strobe_cnt[8:0]) addr_bad <= addr_bad + 1;
        if (sd.sd_buff_dout != (exp_fill ? 8'h00 : (strobe_cnt[7:0] ^ exp_lba8)))
          data_bad <= data_bad + 1;
        strobe_cnt      <= strobe_cnt + 1;
        last_strobe_cyc <= cyc;
      end
      if (mem_rd) rd_seen <= 1'b1;
      if (mem_wr) wr_seen <= 1'b1;
    end
  end

  int wr_base  = 0;
  int fall_cyc = 0;

  task automatic issue(input bit rd, input bit wr, input logic [31:0] lba, input bit fill);
    sd.sd_rd  = rd;
    sd.sd_wr  = wr;
    sd.sd_lba = lba;
    exp_fill  = fill;
    exp_lba8  = lba[7:0];
    wr_base   = wr_done;
    xfer_seq++;
  endtask

  task automatic expect_start(input string tag, input logic exp_err);
    @(negedge clk);
    check_eq({tag, "_ack_rise"}, 32'(sd.sd_ack), 32'd1);
    check_eq({tag, "_err"}, 32'(err), 32'(exp_err));
    check_eq({tag, "_addr0"}, 32'(sd.sd_buff_addr), 32'd0);
    sd.sd_rd  = 1'b0;
    sd.sd_wr  = 1'b0;
    sd.sd_lba = 32'hFFFF_FFFF;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 6000 && sd.sd_ack; i++) @(negedge clk);
    check_eq({tag, "_ack_fall"}, 32'(sd.sd_ack), 32'd0);
    fall_cyc = cyc;
  endtask

  task automatic check_read(input string tag, input bit fill);
    check_eq({tag, "_strobes"}, 32'(strobe_cnt), 32'd512);
    check_eq({tag, "_addr_order"}, 32'(addr_bad), 32'd0);
    check_eq({tag, "_data"}, 32'(data_bad), 32'd0);
    check_eq({tag, "_fall_gap"}, 32'(fall_cyc - last_strobe_cyc), 32'd1);
    check_eq({tag, "_mem_rd"}, 32'(rd_seen), fill ? 32'd0 : 32'd1);
    check_eq({tag, "_mem_wr"}, 32'(wr_seen), 32'd0);
  endtask

  task automatic check_sector_written(input string tag, input int lba);
    int bad;
    bad = 0;
    for (int i = 0; i < 512; i++) begin
      if (mem_byte(lba * 512 + i) != (8'hA5 ^ 8'(i))) bad++;
    end
    check_eq({tag, "_wdata"}, 32'(bad), 32'd0);
    check_eq({tag, "_wcount"}, 32'(wr_done - wr_base), 32'd512);
    check_eq({tag, "_no_strobe"}, 32'(strobe_cnt), 32'd0);
    check_eq({tag, "_no_mem_rd"}, 32'(rd_seen), 32'd0);
  endtask

  initial begin
    reset       = 1'b1;
    sd.sd_rd    = 1'b0;
    sd.sd_wr    = 1'b0;
    sd.sd_lba   = 32'd0;
    img_mounted = 1'b1;
    img_blocks  = 15'd64;
    repeat (3) @(negedge clk);
    check_eq("rst_ack", 32'(sd.sd_ack), 32'd0);
    check_eq("rst_bwr", 32'(sd.sd_buff_wr), 32'd0);
    check_eq("rst_addr", 32'(sd.sd_buff_addr), 32'd0);
    check_eq("rst_bdout", 32'(sd.sd_buff_dout), 32'd0);
    check_eq("rst_mem_rd", 32'(mem_rd), 32'd0);
    check_eq("rst_mem_wr", 32'(mem_wr), 32'd0);
    check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // In-range read, lba 5, latency 2.
    lat = 2;
    issue(1'b1, 1'b0, 32'd5, 1'b0);
    expect_start("t1", 1'b0);
    wait_done("t1");
    check_read("t1", 1'b0);
    repeat (2) @(negedge clk);

    // In-range write, lba 7.
    lat = 1;
    issue(1'b0, 1'b1, 32'd7, 1'b0);
    expect_start("t2", 1'b0);
    wait_done("t2");
    check_sector_written("t2", 7);
    check_eq("t2_first", 32'(mem_byte(32'hE00)), 32'hA5);
    check_eq("t2_last", 32'(mem_byte(32'hFFF)), 32'h5A);
    check_eq("t2_below", 32'(mem_byte(32'hDFF)), 32'hF9);
    check_eq("t2_above", 32'(mem_byte(32'h1000)), 32'h08);
    repeat (2) @(negedge clk);

    // lba == img_blocks: out of range, zero fill.
    lat = 0;
    issue(1'b1, 1'b0, 32'd64, 1'b1);
    expect_start("t3a", 1'b1);
    wait_done("t3a");
    check_read("t3a", 1'b1);
    @(negedge clk);
    check_eq("t3a_err_held", 32'(err), 32'd1);
    @(negedge clk);

    // No image mounted.
    img_mounted = 1'b0;
    issue(1'b1, 1'b0, 32'd3, 1'b1);
    expect_start("t3b", 1'b1);
    wait_done("t3b");
    check_read("t3b", 1'b1);
    img_mounted = 1'b1;
    repeat (2) @(negedge clk);

    // High lba bit set: out-of-range write is drained without memory access.
    issue(1'b0, 1'b1, 32'h0001_0003, 1'b0);
    expect_start("t3c", 1'b1);
    wait_done("t3c");
    check_eq("t3c_no_mem_wr", 32'(wr_seen), 32'd0);
    check_eq("t3c_wcount", 32'(wr_done - wr_base), 32'd0);
    check_eq("t3c_no_strobe", 32'(strobe_cnt), 32'd0);
    repeat (2) @(negedge clk);

    // Both requests high: the write wins.
    issue(1'b1, 1'b1, 32'd9, 1'b0);
    expect_start("t4", 1'b0);
    wait_done("t4");
    check_sector_written("t4", 9);
    repeat (2) @(negedge clk);

    // Reset in the middle of a read.
    lat = 2;
    issue(1'b1, 1'b0, 32'd5, 1'b0);
    expect_start("t5", 1'b0);
    for (int i = 0; i < 2000 && sd.sd_buff_addr != 9'd100; i++) @(negedge clk);
    check_eq("t5_reach100", 32'(sd.sd_buff_addr), 32'd100);
    reset = 1'b1;
    @(negedge clk);
    check_eq("t5_ack", 32'(sd.sd_ack), 32'd0);
    check_eq("t5_mem_rd", 32'(mem_rd), 32'd0);
    check_eq("t5_err", 32'(err), 32'd0);
    check_eq("t5_addr", 32'(sd.sd_buff_addr), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    issue(1'b1, 1'b0, 32'd6, 1'b0);
    expect_start("t5b", 1'b0);
    wait_done("t5b");
    check_read("t5b", 1'b0);
    repeat (2) @(negedge clk);

    // Back-to-back: new request raised on the cycle ack falls.
    lat = 1;
    issue(1'b1, 1'b0, 32'd2, 1'b0);
    expect_start("t6a", 1'b0);
    wait_done("t6a");
    check_read("t6a", 1'b0);
    issue(1'b1, 1'b0, 32'd100, 1'b1);
    @(negedge clk);
    check_eq("t6_gap1", 32'(sd.sd_ack), 32'd0);
    expect_start("t6b", 1'b1);
    wait_done("t6b");
    check_read("t6b", 1'b1);
    issue(1'b1, 1'b0, 32'd3, 1'b0);
    @(negedge clk);
    check_eq("t6_gap2", 32'(sd.sd_ack), 32'd0);
    expect_start("t6c", 1'b0);
    wait_done("t6c");
    check_read("t6c", 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
